hamming_enc_stream: RTL and testbench
=====================================

Name: hamming_enc_stream

Overview:
- Streaming Hamming(15,11) encoder that produces the 15-bit codewords consumed by the downstream decoder `decod`.
- Accepts 11-bit data words on a valid/ready input, computes four even-parity bits, and emits codewords on a valid/ready output through a registered stage with a one-entry skid buffer.
- Supports optional per-word single-bit error injection for exercising the downstream decoder's correction path.
- Keeps a wrap-around count of emitted words.

Parameters:
CNT_W, 16, width of the emitted-word counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input word valid
in_ready  output  1  encoder can accept a word (registered)
in_data  input  11  data word d[10:0]
in_inj_pos  input  4  error-injection position for this word; 0 = none, 1..15 = codeword position to invert
out_valid  output  1  codeword valid
out_ready  input  1  downstream accepts codeword
out_code  output  15  codeword, out_code[i-1] = Hamming position i
out_cnt  output  CNT_W  number of output handshakes since reset, wraps at 2^CNT_W

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Codeword layout:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits d0..d10 occupy positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order.
  - Parity p(k) = XOR of all positions whose index has bit k set (even parity).
- Injection: if in_inj_pos != 0, bit out_code[in_inj_pos-1] is inverted after parity generation. in_inj_pos is captured with its data word and travels with it.
- Handshakes:
  - Input handshake = in_valid & in_ready at a rising edge.
  - Output handshake = out_valid & out_ready at a rising edge.
  - in_valid/in_data must be held stable by the source until accepted; same rule for out_* toward the sink.
- Storage: output register (OR) plus skid register (SK), each holding an encoded codeword.
- in_ready = !SK_full, registered.
- Per edge (rst low):
  - OR empty or output handshake this cycle: OR loads SK if SK full (SK empties), else loads the accepted input word if one is accepted, else OR becomes empty.
  - OR full and no output handshake, with an input accepted: word goes to SK (SK_full=1, in_ready drops next cycle).
  - Simultaneous input and output handshake with SK full cannot occur (in_ready=0).
- out_valid = OR full.
- Latency: a word accepted at edge N is presented on out_code with out_valid=1 after edge N, provided OR was empty or drained at N.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: strictly FIFO. Nothing is ever dropped or duplicated. out_code is stable while out_valid & !out_ready.
- out_cnt increments by 1 on each output handshake; wraps from 2^CNT_W-1 to 0.
- Reset (any cycle, including mid-transfer):
  - out_valid=0, out_code=0, out_cnt=0, SK empty, in_ready=1 after the reset edge.
  - Inputs are ignored while rst=1, and in-flight words are discarded.
- out_code holds its last value when OR empties. Only out_valid qualifies it.

Test Plan:
- Encoding values, inj_pos=0, out_ready=1:
  - in_data=0x000 -> out_code=0x0000.
  - 0x001 -> 0x0007.
  - 0x400 -> 0x408B.
  - 0x7FF -> 0x7FFF.
  - Each codeword appears one cycle after acceptance.
- Streaming: 20 back-to-back words with in_valid=1 and out_ready=1 -> in_ready stays 1, outputs arrive in order one per cycle, out_cnt=20.
- Backpressure: out_ready=0 with words A, B offered -> A held in OR, B in SK, in_ready=0 and stable. Release out_ready -> A then B on consecutive cycles, in_ready back to 1 one cycle after SK drains.
- Injection:
  - in_data=0x001 with in_inj_pos=3 -> out_code=0x0003.
  - in_inj_pos=15 with data 0x000 -> 0x4000.
  - Feed each to `decod` and check it recovers the uncorrupted codeword (0x0007, 0x0000).
- Counter wrap: CNT_W=4, 17 output handshakes -> out_cnt sequence ends 15, 0, 1.
- Reset mid-operation: OR and SK full, assert rst for one edge -> next cycle out_valid=0, out_cnt=0, in_ready=1. The first word after reset is encoded correctly, and no stale word is emitted.

Source files
------------

// File: rtl/hamming_enc_stream_if.sv
// Stream bundle between a word source, the Hamming(15,11) encoder and a codeword sink.
// No logic: carries the input handshake, the output handshake and the emitted-word count.
// The slave modport is the encoder's view; the master modport is the source/sink view.
interface hamming_enc_stream_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_data;
    logic [3:0]       in_inj_pos;
    logic             out_valid;
    logic             out_ready;
    logic [14:0]      out_code;
    logic [CNT_W-1:0] out_cnt;

    modport slave (
        input  in_valid, in_data, in_inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_cnt
    );

    modport master (
        output in_valid, in_data, in_inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_cnt
    );
endinterface

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(15,11) encoder with optional single-bit error injection and an emitted-word counter.
// Latency: one cycle from input acceptance to out_valid when the output register is free.
// Backpressure: output register plus one-entry skid; in_ready (registered) drops while the skid is occupied.
module hamming_enc_stream #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_enc_stream_if.slave  bus
);

    logic [10:0]      w_d;
    logic             w_p1, w_p2, w_p4, w_p8;
    logic [14:0]      w_enc;
    logic [14:0]      w_inj_mask;
    logic [14:0]      w_code;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_or_load;
    logic             w_sk_full_nxt;

    logic             r_or_full;
    logic [14:0]      r_or_code;
    logic             r_sk_full;
    logic [14:0]      r_sk_code;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    assign w_d = bus.in_data;

    // Even parity over the positions whose index has the matching bit set.
    // Data bits sit at positions 3,5,6,7,9,10,11,12,13,14,15 (d0..d10).
    always_comb begin
        w_p1 = ^{w_d[0], w_d[1], w_d[3], w_d[4], w_d[6], w_d[8], w_d[10]};
        w_p2 = ^{w_d[0], w_d[2], w_d[3], w_d[5], w_d[6], w_d[9], w_d[10]};
        w_p4 = ^{w_d[1], w_d[2], w_d[3], w_d[7], w_d[8], w_d[9], w_d[10]};
        w_p8 = ^w_d[10:4];
        // Listed from position 15 down to position 1.
        w_enc = {w_d[10:4], w_p8, w_d[3:1], w_p4, w_d[0], w_p2, w_p1};
    end

    // One-hot flip mask for the requested codeword position; position 0 means no injection.
    always_comb begin
        w_inj_mask = '0;
        for (int i = 1; i < 16; i++) begin
            if (bus.in_inj_pos == 4'(i)) begin
                w_inj_mask[i-1] = 1'b1;
            end
        end
    end

    assign w_code = w_enc ^ w_inj_mask;

    // Handshakes and the skid occupancy that in_ready will reflect next cycle.
    // When the output register is free the skid always drains into it, and no
    // new word can arrive in that cycle because in_ready was low.
    always_comb begin
        w_in_hs       = bus.in_valid & r_in_ready;
        w_out_hs      = r_or_full & bus.out_ready;
        w_or_load     = ~r_or_full | w_out_hs;
        w_sk_full_nxt = w_or_load ? 1'b0 : (r_sk_full | w_in_hs);
    end

    // Output register / skid register movement, registered ready and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_or_full  <= 1'b0;
            r_or_code  <= '0;
            r_sk_full  <= 1'b0;
            r_sk_code  <= '0;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
        end else begin
            if (w_or_load) begin
                if (r_sk_full) begin
                    r_or_code <= r_sk_code;
                    r_or_full <= 1'b1;
                end else if (w_in_hs) begin
                    r_or_code <= w_code;
                    r_or_full <= 1'b1;
                end else begin
                    // Code is left as-is; only out_valid qualifies it.
                    r_or_full <= 1'b0;
                end
            end else if (w_in_hs) begin
                r_sk_code <= w_code;
            end
            r_sk_full  <= w_sk_full_nxt;
            r_in_ready <= ~w_sk_full_nxt;
            if (w_out_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_or_full;
    assign bus.out_code  = r_or_code;
    assign bus.out_cnt   = r_cnt;

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Bench for hamming_enc_stream: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
// Expected codewords come from a syndrome-based reference model and are checked by a queue scoreboard.
// Output backpressure is directed in fixed phases and randomized in the final phase.
module tb_hamming_enc_stream;

    typedef struct {
        logic [14:0] code;
        logic [14:0] clean;
        bit          inj;
    } exp_t;

    logic clk;
    logic rst;
    logic dir_rdy;
    logic rnd_rdy;
    bit   rand_mode;

    int   n_checks;
    int   n_pass;
    int   n_stall;
    int   mcnt;
    exp_t sb[$];

    hamming_enc_stream_if #(.CNT_W(16)) if16 ();
    hamming_enc_stream_if #(.CNT_W(4))  if4  ();

    hamming_enc_stream #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    hamming_enc_stream #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    assign if16.out_ready = rand_mode ? rnd_rdy : dir_rdy;
    assign if4.in_valid   = if16.in_valid;
    assign if4.in_data    = if16.in_data;
    assign if4.in_inj_pos = if16.in_inj_pos;
    assign if4.out_ready  = if16.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference encoder: place data at non-power-of-two positions, then choose the
    // parity bits so the XOR of all set positions' indices (the syndrome) is zero.
    function automatic logic [14:0] enc_model(input logic [10:0] d, input logic [3:0] inj);
        logic [15:0] cw;
        int          s;
        int          k;
        cw = '0;
        s  = 0;
        k  = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        for (int b = 0; b < 4; b++) cw[1 << b] = s[b];
        if (inj != 0) cw[inj] = ~cw[inj];
        return cw[15:1];
    endfunction

    // Reference single-error corrector standing in for the downstream decoder.
    function automatic logic [14:0] dec_model(input logic [14:0] code);
        logic [15:0] cw;
        int          s;
        cw = {code, 1'b0};
        s  = 0;
        for (int p = 1; p < 16; p++) if (cw[p]) s = s ^ p;
        if (s != 0) cw[s] = ~cw[s];
        return cw[15:1];
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Offer one word (entered and left at posedge+1); holds it until accepted.
    task automatic send(input logic [10:0] d, input logic [3:0] inj, input logic [14:0] exp);
        bit   done;
        bit   rdy;
        exp_t e;
        done = 0;
        if16.in_valid   = 1'b1;
        if16.in_data    = d;
        if16.in_inj_pos = inj;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            rdy = if16.in_ready;
            if (!rdy) n_stall++;
            @(posedge clk);
            if (rdy) begin
                e.code  = exp;
                e.clean = enc_model(d, 4'd0);
                e.inj   = (inj != 0);
                sb.push_back(e);
                done = 1;
            end
            #1;
        end
        if (!done) chk(1'b0, "accept_timeout", 32'(if16.in_ready), 32'd1);
        if16.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !if16.out_valid) done = 1;
        end
        if (!done) chk(1'b0, "drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk(if16.out_valid == 1'b0, {tag, "_out_valid"}, 32'(if16.out_valid), 32'd0);
        chk(if16.out_code == 15'd0, {tag, "_out_code"}, 32'(if16.out_code), 32'd0);
        chk(if16.out_cnt == 16'd0, {tag, "_out_cnt"}, 32'(if16.out_cnt), 32'd0);
        chk(if4.out_cnt == 4'd0, {tag, "_out_cnt4"}, 32'(if4.out_cnt), 32'd0);
        chk(if16.in_ready == 1'b1, {tag, "_in_ready"}, 32'(if16.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares each presented codeword at the handshake, checks
    // hold-stability while stalled, counter values and decoder recovery of injected errors.
    bit          have_prev;
    logic [14:0] prev_code;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            mcnt      = 0;
            have_prev = 0;
        end else if (if16.out_valid) begin
            if (have_prev) chk(if16.out_code == prev_code, "hold_stable", 32'(if16.out_code), 32'(prev_code));
            if (if16.out_ready) begin
                have_prev = 0;
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_output", 32'(if16.out_code), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk(if16.out_code == e.code, "code", 32'(if16.out_code), 32'(e.code));
                    chk(if4.out_code == e.code, "code_cnt4", 32'(if4.out_code), 32'(e.code));
                    chk(if16.out_cnt == 16'(mcnt), "out_cnt", 32'(if16.out_cnt), 32'(16'(mcnt)));
                    chk(if4.out_cnt == 4'(mcnt), "out_cnt4", 32'(if4.out_cnt), 32'(4'(mcnt)));
                    if (e.inj) chk(dec_model(if16.out_code) == e.clean, "decode_recover",
                                   32'(dec_model(if16.out_code)), 32'(e.clean));
                    mcnt++;
                end
            end else begin
                have_prev = 1;
                prev_code = if16.out_code;
            end
        end else begin
            have_prev = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    logic [10:0] td   [6] = '{11'h000, 11'h001, 11'h400, 11'h7FF, 11'h001, 11'h000};
    logic [3:0]  tinj [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd15};
    logic [14:0] tcode[6] = '{15'h0000, 15'h0007, 15'h408B, 15'h7FFF, 15'h0003, 15'h4000};

    initial begin
        logic [10:0] a, b, w;
        logic [3:0]  inj;
        int          st0;
        rst             = 1'b1;
        dir_rdy         = 1'b1;
        rand_mode       = 0;
        if16.in_valid   = 1'b0;
        if16.in_data    = '0;
        if16.in_inj_pos = '0;
        n_checks = 0;
        n_pass   = 0;
        n_stall  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Directed encodings and injections, one cycle acceptance-to-output.
        for (int i = 0; i < 6; i++) begin
            send(td[i], tinj[i], tcode[i]);
            chk(if16.out_valid == 1'b1, "latency_valid", 32'(if16.out_valid), 32'd1);
            chk(if16.out_code == tcode[i], "latency_code", 32'(if16.out_code), 32'(tcode[i]));
        end
        drain();

        // Back-to-back streaming from reset; the 4-bit counter wraps through 15,0,1.
        do_reset();
        st0 = n_stall;
        for (int i = 0; i < 20; i++) begin
            w = 11'($urandom);
            send(w, 4'd0, enc_model(w, 4'd0));
        end
        chk(n_stall == st0, "stream_in_ready", 32'(n_stall - st0), 32'd0);
        drain();
        chk(if16.out_cnt == 16'd20, "stream_cnt", 32'(if16.out_cnt), 32'd20);
        chk(if4.out_cnt == 4'd4, "stream_cnt4", 32'(if4.out_cnt), 32'd4);

        // Backpressure: A in the output register, B in the skid.
        dir_rdy = 1'b0;
        a = 11'($urandom);
        b = 11'($urandom);
        send(a, 4'd0, enc_model(a, 4'd0));
        send(b, 4'd0, enc_model(b, 4'd0));
        repeat (3) begin
            @(negedge clk);
            chk(if16.in_ready == 1'b0, "bp_in_ready_low", 32'(if16.in_ready), 32'd0);
            chk(if16.out_valid && if16.out_code == enc_model(a, 4'd0), "bp_hold_a",
                32'(if16.out_code), 32'(enc_model(a, 4'd0)));
        end
        @(posedge clk);
        #1;
        dir_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(if16.in_ready == 1'b1, "bp_in_ready_back", 32'(if16.in_ready), 32'd1);
        chk(if16.out_valid && if16.out_code == enc_model(b, 4'd0), "bp_b_next",
            32'(if16.out_code), 32'(enc_model(b, 4'd0)));
        drain();

        // Reset with both registers full and a word offered during reset.
        dir_rdy = 1'b0;
        a = 11'($urandom);
        b = 11'($urandom);
        send(a, 4'd0, enc_model(a, 4'd0));
        send(b, 4'd0, enc_model(b, 4'd0));
        if16.in_valid = 1'b1;
        if16.in_data  = 11'h155;
        do_reset();
        if16.in_valid = 1'b0;
        check_reset_state("midreset");
        dir_rdy = 1'b1;
        w = 11'h2A5;
        send(w, 4'd0, enc_model(w, 4'd0));
        drain();
        chk(if16.out_cnt == 16'd1, "post_reset_cnt", 32'(if16.out_cnt), 32'd1);

        // Randomized data, injection positions, gaps and output backpressure.
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            w   = 11'($urandom);
            inj = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            send(w, inj, enc_model(w, inj));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
